// File: rtl/risc_v_32_md_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_32_md_ctrl_if
// Description : Bundle between the EX stage and the RV32M multiply/divide
//               sequencer.
//               - master : pipeline side (drives the request, receives the
//                          stall and writeback controls)
//               - slave  : sequencer side
//               Request   : md_req, ex_funct3, ex_rd, divisor_zero, flush
//               Response  : dp_start, dp_is_div, dp_abort, stall, busy,
//                           wb_valid, wb_rd, wb_funct3
// Revision    : 1.0 - initial release
// ============================================================================
interface risc_v_32_md_ctrl_if;
    logic       md_req;
    logic [2:0] ex_funct3;
    logic [4:0] ex_rd;
    logic       divisor_zero;
    logic       flush;

    logic       dp_start;
    logic       dp_is_div;
    logic       dp_abort;
    logic       stall;
    logic       busy;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [2:0] wb_funct3;

    modport master (
        output md_req, ex_funct3, ex_rd, divisor_zero, flush,
        input  dp_start, dp_is_div, dp_abort, stall, busy,
               wb_valid, wb_rd, wb_funct3
    );

    modport slave (
        input  md_req, ex_funct3, ex_rd, divisor_zero, flush,
        output dp_start, dp_is_div, dp_abort, stall, busy,
               wb_valid, wb_rd, wb_funct3
    );
endinterface
`default_nettype wire

// File: rtl/risc_v_32_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_32_md_ctrl
// Description : Sequencer for the RV32M multi-cycle multiply/divide datapath
//               in the EX stage. Accepts one M-extension op, strobes the
//               datapath start, freezes the front of the pipeline while the
//               op iterates and flags the cycle in which the result is ready.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               md   - risc_v_32_md_ctrl_if.slave (request/stall/writeback)
// Parameters  : MUL_CYCLES - busy cycles for MUL/MULH/MULHSU/MULHU (>=1)
//               DIV_CYCLES - busy cycles for DIV/DIVU/REM/REMU (>=1)
//               CNT_W      - counter width, holds max(MUL,DIV)_CYCLES-1
// Build macro : MD_ZERO_SKIP_EN - divide by zero finishes after one busy
//               cycle; when undefined divisor_zero is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_v_32_md_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    risc_v_32_md_ctrl_if.slave md
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_mul_last = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_last = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_is_div;
    logic             w_is_div_nxt;
    logic             r_abort;
    logic             w_abort_nxt;
    logic [4:0]       r_rd;
    logic [4:0]       w_rd_nxt;
    logic [2:0]       r_funct3;
    logic [2:0]       w_funct3_nxt;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_load;

    // Nothing is accepted while reset is asserted, so dp_start and stall stay
    // low even if EX presents a request during reset.
    assign w_accept = (r_state == ST_IDLE) & md.md_req & ~md.flush & ~rst;

    // Counter preload: last iteration index of the accepted op.
`ifdef MD_ZERO_SKIP_EN
    assign w_cnt_load = md.ex_funct3[2] ? (md.divisor_zero ? '0 : c_div_last)
                                        : c_mul_last;
`else
    logic w_unused_divisor_zero;
    assign w_unused_divisor_zero = md.divisor_zero;
    assign w_cnt_load = md.ex_funct3[2] ? c_div_last : c_mul_last;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_abort  <= 1'b0;
            r_rd     <= '0;
            r_funct3 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_abort  <= w_abort_nxt;
            r_rd     <= w_rd_nxt;
            r_funct3 <= w_funct3_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_abort_nxt  = 1'b0;
        w_rd_nxt     = r_rd;
        w_funct3_nxt = r_funct3;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_BUSY;
                    w_cnt_nxt    = w_cnt_load;
                    w_is_div_nxt = md.ex_funct3[2];
                    w_rd_nxt     = md.ex_rd;
                    w_funct3_nxt = md.ex_funct3;
                end
            end
            ST_BUSY: begin
                if (md.flush) begin
                    // Killed mid-iteration: datapath must drop its partial state.
                    w_state_nxt  = ST_IDLE;
                    w_abort_nxt  = 1'b1;
                    w_is_div_nxt = 1'b0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                // The request still visible here is the op just completed.
                w_state_nxt  = ST_IDLE;
                w_is_div_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign md.dp_start  = w_accept;
    assign md.stall     = w_accept | (r_state == ST_BUSY);
    assign md.busy      = (r_state != ST_IDLE);
    assign md.wb_valid  = (r_state == ST_DONE) & ~md.flush;
    assign md.dp_is_div = r_is_div;
    assign md.dp_abort  = r_abort;
    assign md.wb_rd     = r_rd;
    assign md.wb_funct3 = r_funct3;

endmodule
`default_nettype wire
